data_unpacker: RTL

Width converter from 128-bit lines to 16-bit words, the transmit-side counterpart of the 16-to-128 packer. It accepts one 128-bit line per valid/ready handshake and writes its eight 16-bit lanes, lowest lane first, into the downstream `fifo` write port. It honours `full` back-pressure. Words written through `fifo` and then through the packer reproduce the original line bit-for-bit.

---
 rtl/pack_pkg.sv | 21 ++
 rtl/data_unpacker.sv | 101 ++++++++++
 2 files changed

// File: rtl/pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pack_pkg
//  Brief    : Shared widths and types for the 16<->128 packer/unpacker pair.
//  Revision : 1.0  initial release
// ============================================================================
package pack_pkg;

  localparam int WORD_W = 16;
  localparam int LINE_W = 128;
  localparam int LANES  = LINE_W / WORD_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } unpack_state_t;

  typedef logic [$clog2(LANES)-1:0] lane_t;

endpackage : pack_pkg
`default_nettype wire

// File: rtl/data_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : data_unpacker
//  Brief    : Splits a 128-bit line into eight 16-bit words, lowest lane
//             first, and writes them into a FIFO with full back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module data_unpacker #(
  parameter int LINE_W = pack_pkg::LINE_W,
  parameter int WORD_W = pack_pkg::WORD_W,
  parameter int LANES  = LINE_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [LINE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              full,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic              last,
  output logic              busy
);

  import pack_pkg::*;

  localparam int                 LANE_W    = $clog2(LANES);
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(LANES - 1);

  unpack_state_t     state_q, state_d;
  logic [LANE_W-1:0] lane_q,  lane_d;
  logic [LINE_W-1:0] line_q,  line_d;

  logic [WORD_W-1:0] lane_word;

  // Lane select from the held line; only registered state feeds the outputs.
  always_comb begin
    lane_word = line_q[int'(lane_q)*WORD_W +: WORD_W];
  end

  // Next-state and handshake logic; everything is forced quiet during reset.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    line_d   = line_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    last     = 1'b0;
    wr_data  = '0;
    busy     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            line_d  = in_data;
            lane_d  = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          busy    = 1'b1;
          wr_data = lane_word;
          wr_en   = !full;
          if (!full) begin
            if (lane_q == LAST_LANE) begin
              // Last write frees the line register in the same cycle, so a
              // waiting line loads with no bubble between lines.
              last     = 1'b1;
              in_ready = 1'b1;
              if (in_valid) begin
                line_d = in_data;
                lane_d = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, lane counter and line register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      line_q  <= line_d;
    end
  end

endmodule : data_unpacker
`default_nettype wire
